// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline control: fetch PC, IF/ID register, ID/EX control slot and
// saturating stall/flush event counters.
module pipe_front_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              IF_ID_en,
    input  logic              c_or_nop,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [8:0]        ctrl_in,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] IF_ID_pc4,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic              IF_ID_valid,
    output logic [8:0]        ID_EX_ctrl,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    logic              redirect;
    logic [DATA_W-1:0] pc_plus4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF))
            return v + 16'd1;
        return v;
    endfunction

    // A bubbled ID instruction re-issues next cycle, so its branch is not yet final.
    assign redirect = branch_taken & ~c_or_nop;
    assign pc_plus4 = pc + PC_STEP;

    // Fetch / IF-ID / ID-EX stage boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            IF_ID_pc4   <= '0;
            IF_ID_instr <= '0;
            IF_ID_valid <= 1'b0;
            ID_EX_ctrl  <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (redirect)
                pc <= branch_target;
            else if (pc_en)
                pc <= pc_plus4;

            if (redirect) begin
                IF_ID_instr <= '0;
                IF_ID_pc4   <= '0;
                IF_ID_valid <= 1'b0;
            end else if (IF_ID_en) begin
                IF_ID_instr <= instr_in;
                IF_ID_pc4   <= pc_plus4;
                IF_ID_valid <= 1'b1;
            end

            ID_EX_ctrl <= (c_or_nop || !IF_ID_valid) ? 9'd0 : ctrl_in;
            stall_cnt  <= sat_inc(stall_cnt, c_or_nop);
            flush_cnt  <= sat_inc(flush_cnt, redirect);
        end
    end

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed self-checking bench for pipe_front_ctrl with hand-computed expectations.
module tb_pipe_front_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en, IF_ID_en, c_or_nop, branch_taken;
    logic [31:0] branch_target, instr_in;
    logic [8:0]  ctrl_in;
    logic [31:0] pc, IF_ID_pc4, IF_ID_instr;
    logic        IF_ID_valid;
    logic [8:0]  ID_EX_ctrl;
    logic [15:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;

    pipe_front_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_en        (pc_en),
        .IF_ID_en     (IF_ID_en),
        .c_or_nop     (c_or_nop),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_in     (instr_in),
        .ctrl_in      (ctrl_in),
        .pc           (pc),
        .IF_ID_pc4    (IF_ID_pc4),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_valid  (IF_ID_valid),
        .ID_EX_ctrl   (ID_EX_ctrl),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pe, input logic ie, input logic nop,
                         input logic bt, input logic [31:0] tgt, input logic [8:0] c);
        pc_en = pe; IF_ID_en = ie; c_or_nop = nop;
        branch_taken = bt; branch_target = tgt; ctrl_in = c;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_in = 32'h8C010004;
        drive(1, 1, 0, 0, 32'h0, 9'h0AA);
        step(); step();
        check("rst_pc",    pc, 32'h0);
        check("rst_instr", IF_ID_instr, 32'h0);
        check("rst_pc4",   IF_ID_pc4, 32'h0);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'h0);
        check("rst_ctrl",  {23'd0, ID_EX_ctrl}, 32'h0);
        check("rst_stall", {16'd0, stall_cnt}, 32'h0);
        check("rst_flush", {16'd0, flush_cnt}, 32'h0);

        // free run
        rst_n = 1'b1;
        step();
        check("run1_pc",    pc, 32'h4);
        check("run1_pc4",   IF_ID_pc4, 32'h4);
        check("run1_instr", IF_ID_instr, 32'h8C010004);
        check("run1_valid", {31'd0, IF_ID_valid}, 32'h1);
        check("run1_ctrl",  {23'd0, ID_EX_ctrl}, 32'h0);
        step();
        check("run2_pc",   pc, 32'h8);
        check("run2_pc4",  IF_ID_pc4, 32'h8);
        check("run2_ctrl", {23'd0, ID_EX_ctrl}, 32'h0AA);

        // load-use stall
        drive(0, 0, 1, 0, 32'h0, 9'h1FF);
        instr_in = 32'hDEADBEEF;
        step();
        check("stall_pc",    pc, 32'h8);
        check("stall_pc4",   IF_ID_pc4, 32'h8);
        check("stall_instr", IF_ID_instr, 32'h8C010004);
        check("stall_ctrl",  {23'd0, ID_EX_ctrl}, 32'h0);
        check("stall_cnt1",  {16'd0, stall_cnt}, 32'h1);
        instr_in = 32'h8C010004;
        drive(1, 1, 0, 0, 32'h0, 9'h1FF);
        step();
        check("post_stall_ctrl", {23'd0, ID_EX_ctrl}, 32'h1FF);
        check("post_stall_pc",   pc, 32'hC);

        // redirect
        drive(1, 1, 0, 1, 32'h40, 9'h155);
        step();
        check("redir_pc",    pc, 32'h40);
        check("redir_valid", {31'd0, IF_ID_valid}, 32'h0);
        check("redir_instr", IF_ID_instr, 32'h0);
        check("redir_flush", {16'd0, flush_cnt}, 32'h1);
        drive(1, 1, 0, 0, 32'h0, 9'h155);
        step();
        check("redir_bubble_ctrl", {23'd0, ID_EX_ctrl}, 32'h0);
        check("redir_next_pc",     pc, 32'h44);
        check("redir_next_valid",  {31'd0, IF_ID_valid}, 32'h1);

        // branch during bubble is ignored
        drive(0, 0, 1, 1, 32'h80, 9'h155);
        step();
        check("simul_pc",    pc, 32'h44);
        check("simul_flush", {16'd0, flush_cnt}, 32'h1);
        check("simul_stall", {16'd0, stall_cnt}, 32'h2);
        check("simul_valid", {31'd0, IF_ID_valid}, 32'h1);

        // independent enables
        instr_in = 32'h12345678;
        drive(1, 0, 0, 0, 32'h0, 9'h033);
        step();
        check("pconly_pc",    pc, 32'h48);
        check("pconly_pc4",   IF_ID_pc4, 32'h44);
        check("pconly_instr", IF_ID_instr, 32'h8C010004);
        drive(0, 1, 0, 0, 32'h0, 9'h033);
        step();
        check("ifonly_pc",    pc, 32'h48);
        check("ifonly_instr", IF_ID_instr, 32'h12345678);
        check("ifonly_pc4",   IF_ID_pc4, 32'h4C);

        // pc wrap
        drive(1, 1, 0, 1, 32'hFFFFFFFC, 9'h0);
        step();
        check("wrap_tgt", pc, 32'hFFFFFFFC);
        drive(1, 1, 0, 0, 32'h0, 9'h0);
        step();
        check("wrap_pc",  pc, 32'h0);
        check("wrap_pc4", IF_ID_pc4, 32'h0);

        // reset mid-stall with a pending branch
        drive(0, 0, 1, 1, 32'h80, 9'h1FF);
        rst_n = 1'b0;
        step();
        check("rstmid_pc",    pc, 32'h0);
        check("rstmid_valid", {31'd0, IF_ID_valid}, 32'h0);
        check("rstmid_ctrl",  {23'd0, ID_EX_ctrl}, 32'h0);
        check("rstmid_stall", {16'd0, stall_cnt}, 32'h0);
        check("rstmid_flush", {16'd0, flush_cnt}, 32'h0);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 9'h0);
        step();
        check("rel_pc",    pc, 32'h4);
        check("rel_pc4",   IF_ID_pc4, 32'h4);
        check("rel_stall", {16'd0, stall_cnt}, 32'h0);

        // stall counter saturation
        drive(0, 0, 1, 0, 32'h0, 9'h0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
        step();
        check("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
        step(); step(); step();
        check("sat_hold",  {16'd0, stall_cnt}, 32'hFFFF);
        check("sat_flush", {16'd0, flush_cnt}, 32'h0);
        check("sat_pc",    pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_front_ctrl.md
PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 pc_en  input  1  1 = PC may advance; 0 = hold PC (from hazard detection).
REQ-005 IF_ID_en  input  1  1 = IF/ID register may load; 0 = hold.
REQ-006 c_or_nop  input  1  1 = insert bubble (all-zero control) into ID/EX; 0 = pass decoded control.
REQ-007 branch_taken  input  1  branch/jump resolved taken in ID this cycle.
REQ-008 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-009 instr_in  input  32  instruction fetched at the current pc.
REQ-010 ctrl_in  input  9  decoded control word for the instruction currently in IF/ID.
REQ-011 pc  output  32  current fetch address (registered).
REQ-012 IF_ID_pc4  output  32  pc+4 of the instruction held in IF/ID.
REQ-013 IF_ID_instr  output  32  instruction held in IF/ID.
REQ-014 IF_ID_valid  output  1  1 = IF/ID holds a real instruction; 0 = flushed slot.
REQ-015 ID_EX_ctrl  output  9  registered control word entering EX.
REQ-016 stall_cnt  output  16  count of bubble cycles, saturating.
REQ-017 flush_cnt  output  16  count of accepted redirects, saturating.

Function
REQ-018 All outputs SHALL be registered and update only on the rising edge of clk.
REQ-019 Redirect acceptance: redirect = branch_taken AND NOT c_or_nop; when c_or_nop=1, branch_taken SHALL be ignored, because the ID instruction re-issues next cycle.
REQ-020 PC update priority: if redirect, pc <= branch_target; else if pc_en, pc <= pc+4 (mod 2^32, wraps from 0xFFFFFFFC to 0); else pc holds.
REQ-021 IF/ID update priority: if redirect, IF_ID_instr <= 0, IF_ID_pc4 <= 0, IF_ID_valid <= 0; else if IF_ID_en, IF_ID_instr <= instr_in, IF_ID_pc4 <= pc+4, IF_ID_valid <= 1; else all three hold.
REQ-022 ID/EX control: ID_EX_ctrl <= 0 if c_or_nop=1 or IF_ID_valid=0; otherwise ID_EX_ctrl <= ctrl_in; updated every cycle with no hold.
REQ-023 stall_cnt SHALL increment by 1 in each cycle where c_or_nop=1, and hold at 0xFFFF once reached.
REQ-024 flush_cnt SHALL increment by 1 in each cycle where redirect=1, and hold at 0xFFFF once reached.
REQ-025 Load-use stall latency: one stall cycle (pc_en=0, IF_ID_en=0, c_or_nop=1) SHALL freeze pc and IF/ID for exactly one cycle and produce exactly one zero ID_EX_ctrl.
REQ-026 Redirect latency: the target SHALL appear on pc on the edge after branch_taken is sampled; exactly one flushed slot (IF_ID_valid=0) follows.
REQ-027 Inconsistent enable combinations (e.g. pc_en=1 with IF_ID_en=0) SHALL be honoured independently per REQ-020/021, with no error signalling.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set: pc=0, IF_ID_instr=0, IF_ID_pc4=0, IF_ID_valid=0, ID_EX_ctrl=0, stall_cnt=0, flush_cnt=0; all other inputs are ignored.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; the first cycle after release fetches from pc=0.

Verification
REQ-030 Free run: reset, then pc_en=IF_ID_en=1, c_or_nop=0, instr_in=0x8C010004 -> pc sequence 0,4,8; IF_ID_instr=0x8C010004; IF_ID_pc4=4 after the first update; IF_ID_valid=1.
REQ-031 Load-use: at pc=8, one cycle of pc_en=0, IF_ID_en=0, c_or_nop=1, ctrl_in=0x1FF -> pc stays 8, IF_ID holds, ID_EX_ctrl=0, stall_cnt=1; the next cycle ID_EX_ctrl=0x1FF.
REQ-032 Redirect: branch_taken=1, branch_target=0x40 -> pc=0x40, IF_ID_valid=0, flush_cnt=1; the following cycle ID_EX_ctrl=0 regardless of ctrl_in.
REQ-033 Simultaneous: branch_taken=1 with c_or_nop=1 -> no redirect, pc holds per pc_en=0, flush_cnt unchanged, stall_cnt+1.
REQ-034 Saturation/wrap: preload stall_cnt to 0xFFFE via 3 stalls after forcing, or run long; pc at 0xFFFFFFFC with pc_en=1 -> pc=0; stall_cnt stops at 0xFFFF.
REQ-035 Reset mid-stall: rst_n=0 during c_or_nop=1 -> all outputs zero at the next edge; after release pc=0 and counters restart from 0.
